// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller.
// Define DCACHE_STATS_EN to add hit/miss counters.
module dcache_ctrl #(
  parameter int INDEX_W = 5
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_wdata_i,
  output logic [31:0]  cpu_rdata_o,
  output logic         stall_o,
  output logic         mem_ren_o,
  output logic         mem_wen_o,
  output logic [26:0]  mem_addr_o,
  output logic [255:0] mem_wdata_o,
  input  logic [255:0] mem_rdata_i,
`ifdef DCACHE_STATS_EN
  input  logic         mem_ready_i,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
`else
  input  logic         mem_ready_i
`endif
);

  localparam int TAG_W = 27 - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } state_e;

  state_e state_q, state_d;

  logic [255:0]     data_q [LINES];
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [LINES-1:0] valid_q, dirty_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [7:0]         wofs;
  logic               hit, cmp, refill;
  logic               unused;

  assign idx    = cpu_addr_i[4+INDEX_W:5];
  assign tag    = cpu_addr_i[31:5+INDEX_W];
  assign wofs   = {cpu_addr_i[4:2], 5'd0};
  assign hit    = cpu_req_i & valid_q[idx] & (tag_q[idx] == tag);
  assign cmp    = (state_q == COMPARE);
  assign refill = (state_q == ALLOCATE) & mem_ready_i;
  assign unused = ^cpu_addr_i[1:0];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= COMPARE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COMPARE: begin
        if (cpu_req_i && !hit)
          state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: if (mem_ready_i) state_d = ALLOCATE;
      ALLOCATE:  if (mem_ready_i) state_d = COMPARE;
      default:   state_d = COMPARE;
    endcase
  end

  // stall is gated by reset so a mid-miss reset frees the CPU at once
  always_comb begin
    cpu_rdata_o = '0;
    stall_o     = 1'b0;
    mem_ren_o   = 1'b0;
    mem_wen_o   = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (state_q)
      COMPARE: begin
        stall_o = rst_n_i & cpu_req_i & ~hit;
        if (hit && !cpu_we_i)
          cpu_rdata_o = data_q[idx][wofs +: 32];
      end
      WRITEBACK: begin
        stall_o     = rst_n_i;
        mem_wen_o   = 1'b1;
        mem_addr_o  = {tag_q[idx], idx};
        mem_wdata_o = data_q[idx];
      end
      ALLOCATE: begin
        stall_o    = rst_n_i;
        mem_ren_o  = 1'b1;
        mem_addr_o = cpu_addr_i[31:5];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (refill) begin
      data_q[idx] <= mem_rdata_i;
      tag_q[idx]  <= tag;
    end else if (cmp && hit && cpu_we_i) begin
      data_q[idx][wofs +: 32] <= cpu_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (refill) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (cmp && hit && cpu_we_i) begin
      dirty_q[idx] <= 1'b1;
    end
  end

`ifdef DCACHE_STATS_EN
  // the first hit after a refill finishes a miss, so it is not a hit
  logic post_fill_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      post_fill_q <= 1'b0;
      hit_cnt_o   <= '0;
      miss_cnt_o  <= '0;
    end else begin
      post_fill_q <= refill;
      if (cmp && hit && !post_fill_q)
        hit_cnt_o <= hit_cnt_o + 32'd1;
      if (cmp && cpu_req_i && !hit)
        miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller.
- Sits directly upstream of the 256-bit-line data memory, between the CPU load/store port and that memory.
- Converts 32-bit word accesses into whole-line refills and write-backs using the memory's ren/wen/ready handshake.
- Stalls the CPU for the duration of each miss.

Parameters:
- INDEX_W, 5: index bits; cache has 2^INDEX_W lines of 256 bits.
- TAG_W, 27-INDEX_W: tag bits; derived, never overridden.

Ports:
- clk_i, input, 1: clock; all state updates on rising edge.
- rst_n_i, input, 1: asynchronous, active-low reset.
- cpu_req_i, input, 1: CPU access request; held until stall_o is low.
- cpu_we_i, input, 1: 1 = store, 0 = load.
- cpu_addr_i, input, 32: byte address. [4:2] word, [4+INDEX_W:5] index, [31:5+INDEX_W] tag.
- cpu_wdata_i, input, 32: store data.
- cpu_rdata_o, output, 32: load data.
- stall_o, output, 1: CPU must hold its request.
- mem_ren_o, output, 1: line read request.
- mem_wen_o, output, 1: line write request.
- mem_addr_o, output, 27: line address (byte address bits [31:5]).
- mem_wdata_o, output, 256: victim line data.
- mem_rdata_i, input, 256: refill data; valid in the cycle mem_ready_i is high.
- mem_ready_i, input, 1: one-cycle completion pulse from memory.

Behaviour:
- Storage: data[2^INDEX_W]x256, tag[2^INDEX_W]xTAG_W, valid and dirty bits per line.
- Reset (async, rst_n_i low):
  - All valid and dirty bits cleared; state=COMPARE.
  - stall_o=0, mem_ren_o=0, mem_wen_o=0, mem_addr_o=0, mem_wdata_o=0, cpu_rdata_o=0.
  - Data and tag arrays are not reset.
- Hit = cpu_req_i & valid[idx] & (tag[idx]==addr tag).
- COMPARE:
  - Load hit: cpu_rdata_o = word [addr[4:2]] of the line, combinational; stall_o=0.
  - Store hit: at the edge, the 32-bit word at offset addr[4:2] is written and dirty[idx] is set; stall_o=0.
  - Miss (req & !hit): stall_o=1 combinationally in the same cycle.
    - Victim valid & dirty -> WRITEBACK.
    - Otherwise -> ALLOCATE.
  - No request: stall_o=0, stay in COMPARE.
- WRITEBACK:
  - mem_wen_o=1, mem_addr_o={victim tag, idx}, mem_wdata_o=victim line, stall_o=1.
  - Held constant until mem_ready_i; then -> ALLOCATE.
- ALLOCATE:
  - mem_ren_o=1, mem_addr_o=cpu_addr_i[31:5], stall_o=1.
  - On mem_ready_i, at the edge: line = mem_rdata_i, tag written, valid=1, dirty=0; -> COMPARE.
  - COMPARE then hits and completes the access, including merging the store word for a store miss.
- mem_ren_o and mem_wen_o are never high together. Both are low in COMPARE.
- Miss stall length = 1 + Lw + Lr cycles. Lw (0 if clean) and Lr are the cycle counts the respective request is held high, including the ready cycle.
- cpu_addr_i and cpu_we_i change while stall_o=1: protocol violation, behaviour undefined; the bench asserts against it.
- mem_ready_i in COMPARE: ignored.
- Reset mid-miss: the request is dropped immediately.
  - The memory side must be reset or idle before the next access; the bench re-resets both.
- Index aliasing: addresses with equal index and different tag evict each other. Write-back always precedes refill.

Optional Feature:
- Macro DCACHE_STATS_EN.
- When defined, adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - Both reset to 0 and wrap at 2^32.
  - hit_cnt_o increments once per access that completes without entering WRITEBACK or ALLOCATE.
  - miss_cnt_o increments once per COMPARE->WRITEBACK or COMPARE->ALLOCATE transition.
  - The completing post-refill hit is not counted as a hit.
- When undefined, neither port nor counter exists and the behaviour is otherwise identical.

Test Plan:
- Reset, then load 0x0000_0040 (cold):
  - mem_ren_o high with mem_addr_o=0x0000002.
  - Memory returns a line whose word 0 is 0xDEADBEEF, ready after 10 cycles.
  - stall_o high 11 cycles, then cpu_rdata_o=0xDEADBEEF.
- Store 0x12345678 to 0x44 after the above: no stall, no memory traffic. Load 0x44 returns 0x12345678 with stall_o=0.
- Load 0x0000_0440 (same index 2, tag 1) after the dirty store:
  - WRITEBACK first: mem_wen_o=1, mem_addr_o=0x0000002, mem_wdata_o word1=0x12345678.
  - Then ALLOCATE with mem_addr_o=0x0000022.
  - No cycle has both enables high.
- Store miss to clean line 0x0000_0080 with data 0xA5A5A5A5:
  - ALLOCATE only; afterwards dirty[4]=1 and load 0x80 returns 0xA5A5A5A5.
- Assert rst_n_i low during ALLOCATE:
  - mem_ren_o and stall_o drop asynchronously.
  - After release, a load to the same address misses again (valid cleared).
- With DCACHE_STATS_EN, run the sequence above: counters match hand-counted hits and misses exactly.
